// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the external-bus memory responder: FSM state
// encodings, defaults that the cache controller also uses, and the
// reset-vector base used when mapping boot images into the array.
package mem_bus_ctrl_pkg;

  // 3-bit state encodings, kept numeric so they line up with the legacy header
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RLAT   = 3'd1;
  localparam logic [2:0] ST_RBURST = 3'd2;
  localparam logic [2:0] ST_WLAT   = 3'd3;
  localparam logic [2:0] ST_WACK   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef logic [2:0] bus_state_t;

  // Defaults shared with the CPU cache controller
  localparam int DEF_LINE_WORDS    = 4;
  localparam int DEF_READ_LATENCY  = 4;
  localparam int DEF_WRITE_LATENCY = 2;

  // Latency counters must hold values up to 15
  localparam int CNT_W = 4;

  // Boot ROM base; word 0 of a preload image corresponds to this byte address
  localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;

  // Width of the beat counter; a one-word line still needs a 1-bit counter
  function automatic int beat_width(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_array.sv
// Single-port synchronous word RAM backing the memory responder.
// Reads are registered (read-first on a simultaneous write), so data
// for an address presented this cycle appears after the next edge.
module mem_array #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  // Write on enable and register the read word every cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side responder on the CPU external bus. Services cache line
// fills as fixed-latency sequential read bursts and word stores as
// single-beat writes, all backed by an on-chip word array.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 14,
  parameter int LINE_WORDS    = DEF_LINE_WORDS,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic        CLK,
  input  logic        MRST_N,
  input  logic [31:0] Addr,
  input  logic        Read,
  input  logic        Write,
  inout  wire  [31:0] Bus,
  output logic        Valid
);

  localparam int                BEAT_W    = beat_width(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  RD_CNT0   = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0]  WR_CNT0   = CNT_W'(WRITE_LATENCY - 1);

  bus_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BEAT_W-1:0] beat_q;
  logic [ADDR_W-1:0] index_q;
  logic              valid_q;

  logic [ADDR_W-1:0] word_index;
  logic [ADDR_W-1:0] fetch_off;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              bus_drive;
  logic              rburst_abort;
  logic              unused_addr_bits;

  // Upper address bits wrap and the byte offset is meaningless for word accesses
  assign word_index       = Addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{Addr[31:ADDR_W+2], Addr[1:0]};

  // Main transaction FSM with latency counter, beat counter and latched index
  always_ff @(posedge CLK or negedge MRST_N) begin
    if (!MRST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (Write) begin
            state_q <= ST_WLAT;
            index_q <= word_index;
            cnt_q   <= WR_CNT0;
          end else if (Read) begin
            state_q <= ST_RLAT;
            index_q <= word_index & LINE_MASK;
            cnt_q   <= RD_CNT0;
            beat_q  <= '0;
          end
        end
        ST_RLAT: begin
          if (!Read) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= ST_RBURST;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RBURST: begin
          if (!Read) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end else if (beat_q == LAST_BEAT) begin
            state_q <= ST_DONE;
            valid_q <= 1'b0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        ST_WLAT: begin
          if (!Write) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= ST_WACK;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WACK: begin
          state_q <= ST_DONE;
          valid_q <= 1'b0;
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          if (!Read && !Write) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Array port: the write target during WLAT, otherwise the next beat to prefetch
  always_comb begin
    fetch_off = '0;
    if (state_q == ST_RBURST) begin
      fetch_off = ADDR_W'(beat_q) + ADDR_W'(1);
    end
    mem_we   = (state_q == ST_WLAT) && Write && (cnt_q == '0);
    mem_addr = (state_q == ST_WLAT) ? index_q : (index_q + fetch_off);
  end

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (Bus),
    .rdata (mem_rdata)
  );

  // Drive enable follows Read directly so a dropped fill releases the bus at once
  assign rburst_abort = (state_q == ST_RBURST) && !Read;
  assign bus_drive    = (state_q == ST_RBURST) && Read;
  assign Bus          = bus_drive ? mem_rdata : 'z;
  assign Valid        = valid_q && !rburst_abort;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios plus a randomized
// mix of fills, stores and aborts, checked against a word-level memory model.
module tb_mem_bus_ctrl;

  localparam int RL = 4;
  localparam int WL = 2;
  localparam int LW = 4;

  logic        CLK;
  logic        MRST_N;
  logic [31:0] Addr;
  logic        Read;
  logic        Write;
  logic [31:0] bus_drv;
  logic        bus_en;
  wire  [31:0] Bus;
  logic        Valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [int];

  assign Bus = bus_en ? bus_drv : 'z;

  mem_bus_ctrl #(
    .ADDR_W        (14),
    .LINE_WORDS    (LW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .CLK    (CLK),
    .MRST_N (MRST_N),
    .Addr   (Addr),
    .Read   (Read),
    .Write  (Write),
    .Bus    (Bus),
    .Valid  (Valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic drive);
    Read    = rd;
    Write   = wr;
    Addr    = a;
    bus_drv = d;
    bus_en  = drive;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Probe the bus with a zero driver; a released bus then reads back as zero
  task automatic busProbe(output logic [31:0] v);
    logic        save_en;
    logic [31:0] save_drv;
    save_en  = bus_en;
    save_drv = bus_drv;
    bus_en   = 1'b1;
    bus_drv  = '0;
    #1;
    v       = Bus;
    bus_en  = save_en;
    bus_drv = save_drv;
    #1;
  endtask

  task automatic checkReleased(input string tag);
    logic [31:0] v;
    busProbe(v);
    checkOutput(tag, v, 32'h0);
  endtask

  function automatic int wordIdx(input logic [31:0] a);
    return int'(a[15:2]);
  endfunction

  function automatic logic [31:0] refWord(input int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return 32'hxxxx_xxxx;
  endfunction

  // Random byte address that maps to word idx, with random wrap and byte bits
  function automatic logic [31:0] mkAddr(input int idx);
    logic [31:0] r;
    r       = $urandom;
    r[15:2] = idx[13:0];
    return r;
  endfunction

  // Store: Valid pulses exactly WL edges after the sampling edge
  task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic also_read);
    applyStimulus(also_read, 1'b1, a, d, 1'b1);
    for (int i = 0; i <= WL + 1; i++) begin
      step();
      checkOutput("wr valid", {31'b0, Valid}, {31'b0, (i == WL)});
      checkOutput("wr bus", Bus, d);
    end
    applyStimulus(1'b0, 1'b0, a, 32'h0, 1'b0);
    step();
    checkOutput("wr idle valid", {31'b0, Valid}, 32'h0);
    ref_mem[wordIdx(a)] = d;
  endtask

  // Fill: hold < 0 runs the full burst, otherwise Read drops after edge 'hold'
  task automatic doRead(input logic [31:0] a, input int hold);
    int base;
    int last;
    base = wordIdx(a) & ~(LW - 1);
    last = (hold < 0) ? (RL + LW) : hold;
    applyStimulus(1'b1, 1'b0, a, 32'h0, 1'b0);
    for (int i = 0; i <= last; i++) begin
      step();
      if (i >= RL && i < RL + LW) begin
        checkOutput("rd valid", {31'b0, Valid}, 32'h1);
        checkOutput("rd data", Bus, refWord(base + i - RL));
      end else begin
        checkOutput("rd valid", {31'b0, Valid}, 32'h0);
        checkReleased("rd released");
      end
    end
    Read = 1'b0;
    #1;
    checkOutput("rd drop valid", {31'b0, Valid}, 32'h0);
    checkReleased("rd drop released");
    step();
    checkOutput("rd idle valid", {31'b0, Valid}, 32'h0);
  endtask

  // Store abandoned after edge 'hold', before the commit edge
  task automatic doWriteAbort(input logic [31:0] a, input logic [31:0] d, input int hold);
    applyStimulus(1'b0, 1'b1, a, d, 1'b1);
    for (int i = 0; i <= hold; i++) begin
      step();
      checkOutput("wabort valid", {31'b0, Valid}, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, a, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("wabort after valid", {31'b0, Valid}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    int          idx;
    int          h;

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    MRST_N = 1'b0;
    #2;
    checkOutput("reset valid", {31'b0, Valid}, 32'h0);
    checkReleased("reset released");
    repeat (3) step();
    MRST_N = 1'b1;
    step();
    checkOutput("post reset valid", {31'b0, Valid}, 32'h0);

    // Preload words 0x40..0x8F through the bus; 0x40..0x43 get recognisable values
    for (int w = 16'h40; w <= 16'h8F; w++) begin
      d = (w < 16'h44) ? (32'h0000_00A0 + 32'(w - 16'h40)) : $urandom;
      doWrite(mkAddr(w), d, 1'b0);
    end

    $display("[TB] directed fill");
    doRead(32'h0000_0108, -1);

    $display("[TB] store then fill");
    doWrite(32'h0000_010C, 32'hDEAD_BEEF, 1'b0);
    doRead(32'h0000_0100, -1);
    checkOutput("model beat3", refWord(16'h43), 32'hDEAD_BEEF);

    $display("[TB] read abort after second beat");
    doRead(32'h0000_0100, RL + 1);
    doRead(32'h0000_0200, -1);

    $display("[TB] simultaneous read and write");
    doWrite(32'h0000_0204, 32'h1234_5678, 1'b1);
    doRead(32'h0000_0200, -1);

    $display("[TB] write abort");
    doWriteAbort(32'h0000_0208, 32'hBAD0_BAD0, 1);
    doRead(32'h0000_0200, -1);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    for (int i = 0; i <= RL + 1; i++) begin
      step();
      checkOutput("rst burst valid", {31'b0, Valid}, {31'b0, (i >= RL)});
    end
    MRST_N = 1'b0;
    #1;
    checkOutput("rst async valid", {31'b0, Valid}, 32'h0);
    checkReleased("rst async released");
    Read = 1'b0;
    repeat (3) begin
      step();
      checkOutput("rst hold valid", {31'b0, Valid}, 32'h0);
    end
    MRST_N = 1'b1;
    step();
    doRead(32'h0000_0100, -1);

    $display("[TB] reset mid-write");
    applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h5555_AAAA, 1'b1);
    for (int i = 0; i < WL; i++) begin
      step();
      checkOutput("rst wr valid", {31'b0, Valid}, 32'h0);
    end
    MRST_N = 1'b0;
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("rst wr async valid", {31'b0, Valid}, 32'h0);
    repeat (3) step();
    MRST_N = 1'b1;
    step();
    doRead(32'h0000_0100, -1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 60; n++) begin
      op  = $urandom_range(0, 4);
      idx = $urandom_range(16'h40, 16'h8F);
      a   = mkAddr(idx);
      case (op)
        0: doWrite(a, $urandom, 1'b0);
        1: doWrite(a, $urandom, 1'b1);
        2: doRead(a, -1);
        3: begin
          h = $urandom_range(0, RL + LW - 1);
          doRead(a, h);
        end
        default: begin
          h = $urandom_range(0, WL - 1);
          doWriteAbort(a, $urandom, h);
        end
      endcase
    end
    for (int line = 16'h40; line <= 16'h8F; line += LW) begin
      doRead(mkAddr(line), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
